// File: rtl/iter_mult_unit.sv
// ---------------------------------------------------------------------------
// iter_mult_unit
//   Multi-cycle radix-2 shift-add multiplier for the execute stage. Operands
//   are converted to magnitudes when signed, multiplied over WIDTH iteration
//   cycles, and the product is negated at the end if the operand signs
//   differed. The 64-bit (2*WIDTH) product is held on hi/lo until the next
//   completion, so the out-select mux can read it at any time.
//
// Ports
//   clk       in   1      rising-edge clock
//   reset     in   1      asynchronous, active-low (0 = in reset)
//   start     in   1      operation request, sampled only while busy=0
//   sign      in   1      1 = two's complement operands, 0 = unsigned
//   flush     in   1      synchronous abort of the in-flight operation
//   a         in   WIDTH  multiplicand, captured on the start edge
//   b         in   WIDTH  multiplier, captured on the start edge
//   busy      out  1      high while an operation is in flight
//   done      out  1      one-cycle pulse, hi/lo were just updated
//   hi        out  WIDTH  product[2*WIDTH-1:WIDTH]
//   lo        out  WIDTH  product[WIDTH-1:0]
//   dbgState  out  2      current FSM state (0 IDLE, 1 RUN, 2 FIN)
//
// Handshake: a request is accepted on a rising edge where start=1, flush=0
// and busy=0. Requests seen while busy=1 are dropped (no queueing); the
// producer must watch busy. The result is announced by done for one cycle,
// and a new start may be accepted in that same cycle.
// ---------------------------------------------------------------------------
module iter_mult_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sign,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       dbgState
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t             state;
    state_t             stateNext;

    // magA is kept 2*WIDTH wide and shifted left once per iteration, which
    // is the same as adding mag_a << cnt without a variable shifter.
    logic [2*WIDTH-1:0] magA;
    logic [WIDTH-1:0]   magB;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic               neg;

    logic [WIDTH-1:0]   absA;
    logic [WIDTH-1:0]   absB;
    logic               accept;

    // The most negative value negates to itself, which read as unsigned is
    // exactly its magnitude, so no special case is needed.
    assign absA   = (sign && a[WIDTH-1]) ? -a : a;
    assign absB   = (sign && b[WIDTH-1]) ? -b : b;
    assign accept = start && !flush;

    assign dbgState = state;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // RUN holds WIDTH iteration edges; the edge that finds cnt==WIDTH hands
    // over to FIN, which writes the result on its own edge.
    // -----------------------------------------------------------------------
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    stateNext = RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    stateNext = IDLE;
                end else if (cnt == CNT_LAST) begin
                    stateNext = FIN;
                end
            end
            FIN: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath and registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            magA <= '0;
            magB <= '0;
            acc  <= '0;
            cnt  <= '0;
            neg  <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            hi   <= '0;
            lo   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        magA <= {{WIDTH{1'b0}}, absA};
                        magB <= absB;
                        neg  <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc  <= '0;
                        cnt  <= '0;
                        busy <= 1'b1;
                    end
                end
                RUN: begin
                    if (flush) begin
                        busy <= 1'b0;
                    end else if (cnt != CNT_LAST) begin
                        if (magB[0]) begin
                            acc <= acc + magA;
                        end
                        magA <= magA << 1;
                        magB <= magB >> 1;
                        cnt  <= cnt + CW'(1);
                    end
                end
                FIN: begin
                    busy <= 1'b0;
                    if (!flush) begin
                        {hi, lo} <= neg ? -acc : acc;
                        done     <= 1'b1;
                    end
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_mult_unit.sv
// ---------------------------------------------------------------------------
// tb_iter_mult_unit
//   Directed self-checking bench for iter_mult_unit (WIDTH=32). Inputs are
//   driven 1 time unit after a rising edge and outputs are sampled at the
//   same point, so "after edge N" below means the value registered on
//   edge N counted from the start edge (edge 0).
// ---------------------------------------------------------------------------
module tb_iter_mult_unit;

    localparam int W = 32;
    localparam int MAX_WAIT = 60;

    logic         clk;
    logic         reset;
    logic         start;
    logic         sign;
    logic         flush;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [1:0]   dbgState;

    int checks;
    int errors;

    iter_mult_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .sign     (sign),
        .flush    (flush),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .dbgState (dbgState)
    );

    // -----------------------------------------------------------------------
    // Clock
    // -----------------------------------------------------------------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // -----------------------------------------------------------------------
    // Driver helpers (no checking inside)
    // -----------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request across a single rising edge (the start edge),
    // then scrambles the operand inputs, which the unit must not depend on.
    task automatic pulseStart(input logic [W-1:0] opA, input logic [W-1:0] opB,
                              input logic isSigned);
        a     = opA;
        b     = opB;
        sign  = isSigned;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = 32'hDEAD_BEEF;
        b     = 32'h1234_5678;
        sign  = ~isSigned;
    endtask

    // Called right after the start edge. Returns the edge index on which done
    // was first seen (-1 if never within MAX_WAIT) and how many sampled
    // cycles before that busy was high (the sample after edge 0 included).
    task automatic waitDone(output int lat, output int busyCnt);
        lat     = -1;
        busyCnt = busy ? 1 : 0;
        for (int i = 1; i <= MAX_WAIT; i++) begin
            tick();
            if (done) begin
                lat = i;
                break;
            end
            if (busy) busyCnt++;
        end
    endtask

    // -----------------------------------------------------------------------
    // Tests
    // -----------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        sign  = 1'b0;
        flush = 1'b0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done: got %b expected 0", done);
        end
        checks++;
        if ({hi, lo} !== 64'h0) begin
            errors++;
            $display("FAIL reset_hilo: got %h_%h expected 0_0", hi, lo);
        end
        checks++;
        if (dbgState !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d expected 0", dbgState);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_unsigned();
        int lat;
        int busyCnt;
        pulseStart(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL unsigned_busy_on_start: got %b expected 1", busy);
        end
        waitDone(lat, busyCnt);
        checks++;
        if (lat !== 34) begin
            errors++;
            $display("FAIL unsigned_latency: got %0d expected 34", lat);
        end
        checks++;
        if (busyCnt !== 34) begin
            errors++;
            $display("FAIL unsigned_busy_cycles: got %0d expected 34", busyCnt);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL unsigned_busy_in_done: got %b expected 0", busy);
        end
        checks++;
        if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
            errors++;
            $display("FAIL unsigned_product: got %h_%h expected fffffffe_00000001", hi, lo);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL unsigned_done_width: got %b expected 0", done);
        end
        checks++;
        if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
            errors++;
            $display("FAIL unsigned_hold: got %h_%h expected fffffffe_00000001", hi, lo);
        end
    endtask

    task automatic test_signed();
        logic [W-1:0] vecA  [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0007};
        logic [W-1:0] vecB  [4] = '{32'h0000_0005, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFA};
        logic [W-1:0] expHi [4] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h4000_0000, 32'hFFFF_FFFF};
        logic [W-1:0] expLo [4] = '{32'hFFFF_FFF1, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFD6};
        int lat;
        int busyCnt;
        for (int i = 0; i < 4; i++) begin
            pulseStart(vecA[i], vecB[i], 1'b1);
            waitDone(lat, busyCnt);
            checks++;
            if (lat !== 34) begin
                errors++;
                $display("FAIL signed_latency[%0d]: got %0d expected 34", i, lat);
            end
            checks++;
            if (hi !== expHi[i] || lo !== expLo[i]) begin
                errors++;
                $display("FAIL signed_product[%0d]: got %h_%h expected %h_%h",
                         i, hi, lo, expHi[i], expLo[i]);
            end
            tick();
        end
    endtask

    task automatic test_start_while_busy();
        int doneCnt;
        int firstDone;
        doneCnt   = 0;
        firstDone = -1;
        pulseStart(32'd3, 32'd4, 1'b0);
        for (int i = 1; i <= 80; i++) begin
            if (i == 10) begin
                a     = 32'd1000;
                b     = 32'd1000;
                sign  = 1'b0;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            if (done) begin
                doneCnt++;
                if (firstDone < 0) firstDone = i;
            end
        end
        start = 1'b0;
        checks++;
        if (doneCnt !== 1) begin
            errors++;
            $display("FAIL busy_start_done_count: got %0d expected 1", doneCnt);
        end
        checks++;
        if (firstDone !== 34) begin
            errors++;
            $display("FAIL busy_start_latency: got %0d expected 34", firstDone);
        end
        checks++;
        if (hi !== 32'd0 || lo !== 32'd12) begin
            errors++;
            $display("FAIL busy_start_product: got %h_%h expected 00000000_0000000c", hi, lo);
        end
    endtask

    task automatic test_flush();
        int lat;
        int busyCnt;
        int doneCnt;
        pulseStart(32'd7, 32'd6, 1'b0);
        waitDone(lat, busyCnt);
        checks++;
        if (hi !== 32'd0 || lo !== 32'd42) begin
            errors++;
            $display("FAIL flush_prior_product: got %h_%h expected 00000000_0000002a", hi, lo);
        end
        tick();
        pulseStart(32'd100, 32'd100, 1'b0);
        for (int i = 1; i <= 15; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_busy_drop: got %b expected 0", busy);
        end
        checks++;
        if (dbgState !== 2'd0) begin
            errors++;
            $display("FAIL flush_state: got %0d expected 0", dbgState);
        end
        doneCnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) doneCnt++;
        end
        checks++;
        if (doneCnt !== 0) begin
            errors++;
            $display("FAIL flush_no_done: got %0d pulses expected 0", doneCnt);
        end
        checks++;
        if (hi !== 32'd0 || lo !== 32'd42) begin
            errors++;
            $display("FAIL flush_hold: got %h_%h expected 00000000_0000002a", hi, lo);
        end
        // Flush together with start while idle must not launch anything.
        a     = 32'd5;
        b     = 32'd5;
        start = 1'b1;
        flush = 1'b1;
        tick();
        start = 1'b0;
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_with_start: got busy %b expected 0", busy);
        end
        pulseStart(32'd9, 32'd9, 1'b0);
        waitDone(lat, busyCnt);
        checks++;
        if (lat !== 34 || hi !== 32'd0 || lo !== 32'd81) begin
            errors++;
            $display("FAIL flush_restart: got lat %0d %h_%h expected 34 00000000_00000051",
                     lat, hi, lo);
        end
        tick();
    endtask

    task automatic test_async_reset();
        int lat;
        int busyCnt;
        pulseStart(32'd5, 32'd5, 1'b0);
        for (int i = 1; i <= 20; i++) tick();
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: got busy %b done %b %h_%h expected 0 0 0_0",
                     busy, done, hi, lo);
        end
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || dbgState !== 2'd0) begin
            errors++;
            $display("FAIL async_reset_release: got busy %b state %0d expected 0 0",
                     busy, dbgState);
        end
        pulseStart(32'h0001_0000, 32'h0001_0000, 1'b0);
        waitDone(lat, busyCnt);
        checks++;
        if (lat !== 34 || hi !== 32'd1 || lo !== 32'd0) begin
            errors++;
            $display("FAIL async_reset_after: got lat %0d %h_%h expected 34 00000001_00000000",
                     lat, hi, lo);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int lat;
        int busyCnt;
        pulseStart(32'd3, 32'd7, 1'b0);
        waitDone(lat, busyCnt);
        checks++;
        if (lat !== 34 || hi !== 32'd0 || lo !== 32'd21) begin
            errors++;
            $display("FAIL b2b_first: got lat %0d %h_%h expected 34 00000000_00000015",
                     lat, hi, lo);
        end
        // Still inside the done cycle: issue the next request now.
        pulseStart(32'hFFFF_FFFE, 32'd3, 1'b1);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: got busy %b done %b expected 1 0", busy, done);
        end
        waitDone(lat, busyCnt);
        checks++;
        if (lat !== 34) begin
            errors++;
            $display("FAIL b2b_second_latency: got %0d expected 34", lat);
        end
        checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
            errors++;
            $display("FAIL b2b_second_product: got %h_%h expected ffffffff_fffffffa", hi, lo);
        end
        tick();
    endtask

    // -----------------------------------------------------------------------
    // Sequence and report
    // -----------------------------------------------------------------------
    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_start_while_busy();
        test_flush();
        test_async_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
